// File: rtl/usb_pkt_router.sv
`default_nettype none
// ============================================================================
//  Module   : usb_pkt_router
//  Purpose  : Ingest router from the USB3 slave-FIFO read stream into the
//             per-channel DA sample RAMs. It hunts header words, decodes the
//             channel and payload length, and steers payload words to one
//             channel RAM through a registered one-hot write port.
//  Options  : BANK_SWAP_EN - per-channel ping-pong bank bit in ch_addr[AW],
//             toggled on each completed packet, plus the bank_vec output.
//  Revision : 1.0 - initial release
// ============================================================================
module usb_pkt_router #(
   parameter int DATA_W   = 32,
   parameter int NUM_CH   = 24,
   parameter int CH_DEPTH = 256
) (
   input  logic                        wrclock,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic [DATA_W-1:0]           s_data,
   input  logic                        s_valid,
   input  logic                        s_last,
   output logic                        s_ready,
   output logic [NUM_CH-1:0]           ch_wren,
   output logic [$clog2(CH_DEPTH):0]   ch_addr,
   output logic [DATA_W-1:0]           ch_data,
   output logic                        pkt_done,
   output logic [7:0]                  pkt_ch,
   output logic                        err_short,
   output logic [2:0]                  err_sticky,
   output logic [15:0]                 drop_cnt
`ifdef BANK_SWAP_EN
   ,
   output logic [NUM_CH-1:0]           bank_vec
`endif
);

   localparam int AW = $clog2(CH_DEPTH);
   // Word counter must hold both the 8-bit length field and a full RAM address.
   localparam int CW = (AW > 8) ? AW : 8;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_DROP    = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [7:0]        r_ch;
   logic [7:0]        r_len_m1;
   logic [CW-1:0]     r_wcnt;

   logic              w_accept;
   logic              w_is_hdr;
   logic [7:0]        w_hdr_ch;
   logic [7:0]        w_hdr_len_m1;
   logic              w_ch_ok;
   logic              w_len_big;
   logic              w_last_word;
   logic [NUM_CH-1:0] w_onehot;
   logic              w_bank_sel;

   logic              w_wr;
   logic              w_done;
   logic              w_short;
   logic              w_hdr_ok;
   logic              w_hdr_bad;
   logic              w_hdr_trunc;
   logic              w_wcnt_inc;
   logic              w_drop_inc;

   // Ready is forced low while reset is held so no word is taken mid-reset.
   assign s_ready      = en & rst_n;
   assign w_accept     = s_valid & s_ready;
   assign w_is_hdr     = (s_data[31:24] == 8'hFF) && (s_data[7:0] == 8'hFF);
   assign w_hdr_ch     = s_data[23:16];
   assign w_hdr_len_m1 = s_data[15:8];
   assign w_ch_ok      = ({1'b0, w_hdr_ch} < 9'(NUM_CH));
   assign w_len_big    = (32'(w_hdr_len_m1) >= 32'(CH_DEPTH));
   assign w_last_word  = (r_wcnt == CW'(r_len_m1));
   assign w_onehot     = NUM_CH'(1'b1) << r_ch;

`ifdef BANK_SWAP_EN
   logic [NUM_CH-1:0] r_bank;

   // Write bank per channel flips only when a packet completes normally.
   always_ff @(posedge wrclock or negedge rst_n) begin
      if (!rst_n) begin
         r_bank <= '0;
      end else if (w_done) begin
         r_bank <= r_bank ^ w_onehot;
      end
   end

   assign w_bank_sel = |(r_bank & w_onehot);
   assign bank_vec   = ~r_bank;
`else
   assign w_bank_sel = 1'b0;
`endif

   // State register.
   always_ff @(posedge wrclock or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and per-cycle action strobes for the datapath.
   always_comb begin
      w_state_nxt = r_state;
      w_wr        = 1'b0;
      w_done      = 1'b0;
      w_short     = 1'b0;
      w_hdr_ok    = 1'b0;
      w_hdr_bad   = 1'b0;
      w_hdr_trunc = 1'b0;
      w_wcnt_inc  = 1'b0;
      w_drop_inc  = 1'b0;
      unique case (r_state)
         ST_HUNT: begin
            if (w_accept) begin
               if (w_is_hdr) begin
                  // A header that closes the burst carries no payload at all.
                  if (s_last) begin
                     w_hdr_trunc = 1'b1;
                  end else if (w_ch_ok) begin
                     w_hdr_ok    = 1'b1;
                     w_state_nxt = ST_PAYLOAD;
                  end else begin
                     w_hdr_bad   = 1'b1;
                     w_state_nxt = ST_DROP;
                  end
               end else begin
                  w_drop_inc = 1'b1;
               end
            end
         end
         ST_PAYLOAD: begin
            if (w_accept) begin
               w_wr       = 1'b1;
               w_wcnt_inc = 1'b1;
               if (w_last_word) begin
                  w_done      = 1'b1;
                  w_state_nxt = ST_HUNT;
               end else if (s_last) begin
                  w_short     = 1'b1;
                  w_state_nxt = ST_HUNT;
               end
            end
         end
         ST_DROP: begin
            if (w_accept) begin
               w_wcnt_inc = 1'b1;
               if (w_last_word || s_last) begin
                  w_state_nxt = ST_HUNT;
               end
            end
         end
         default: begin
            w_state_nxt = ST_HUNT;
         end
      endcase
   end

   // Packet context, RAM write port, status pulses and counters.
   always_ff @(posedge wrclock or negedge rst_n) begin
      if (!rst_n) begin
         r_ch       <= '0;
         r_len_m1   <= '0;
         r_wcnt     <= '0;
         ch_wren    <= '0;
         ch_addr    <= '0;
         ch_data    <= '0;
         pkt_done   <= 1'b0;
         pkt_ch     <= '0;
         err_short  <= 1'b0;
         err_sticky <= '0;
         drop_cnt   <= '0;
      end else begin
         ch_wren   <= w_wr ? w_onehot : '0;
         pkt_done  <= w_done;
         err_short <= w_short | w_hdr_trunc;

         if (w_wr) begin
            ch_addr <= {w_bank_sel, r_wcnt[AW-1:0]};
            ch_data <= s_data;
         end

         if (w_hdr_trunc) begin
            pkt_ch <= w_hdr_ch;
         end else if (w_done || w_short) begin
            pkt_ch <= r_ch;
         end

         if (w_hdr_ok || w_hdr_bad) begin
            r_len_m1 <= w_hdr_len_m1;
            r_wcnt   <= '0;
         end else if (w_wcnt_inc) begin
            r_wcnt <= r_wcnt + 1'b1;
         end

         if (w_hdr_ok) begin
            r_ch <= w_hdr_ch;
         end

         err_sticky <= err_sticky | {w_hdr_ok & w_len_big,
                                     w_short | w_hdr_trunc,
                                     w_hdr_bad};

         if (w_drop_inc && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire
